// File: rtl/decoder_serial_framer.sv
`default_nettype none
//==============================================================================
// Module : decoder_serial_framer
// Brief  : Synchronises a serial pin and frames start / WORD_W data (LSB first)
//          / stop into parallel words behind a one-entry valid/ready register.
//          Define DECODER_FRAMER_PARITY_EN to add an even-parity bit before stop.
// Rev    : 1.0 - initial release
//==============================================================================
module decoder_serial_framer #(
    parameter int WORD_W      = 7,
    parameter int OVERSAMPLE  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              serial_in,
    output logic [WORD_W-1:0] word_out,
    output logic              word_valid,
    input  logic              word_ready,
    output logic              frame_err,
    output logic              overrun
);

    localparam int c_CNT_W = (OVERSAMPLE > 2) ? $clog2(OVERSAMPLE) : 1;
    localparam int c_BIT_W = $clog2(WORD_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_HALF = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_BIT_LAST = c_BIT_W'(WORD_W - 1);

    typedef enum logic [2:0] {
        S_BREAK  = 3'd0,
        S_IDLE   = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_STOP   = 3'd4
`ifdef DECODER_FRAMER_PARITY_EN
        ,
        S_PARITY = 3'd5
`endif
    } state_t;

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_q;

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_nxt;
    logic [c_BIT_W-1:0]     r_bit;
    logic [c_BIT_W-1:0]     w_bit_nxt;
    logic [WORD_W-1:0]      r_shift;
    logic [WORD_W-1:0]      w_shift_nxt;
    logic                   w_word_done;
    logic                   w_word_bad;
`ifdef DECODER_FRAMER_PARITY_EN
    logic                   r_par_err;
    logic                   w_par_err_nxt;
`endif

    logic [WORD_W-1:0]      r_word;
    logic                   r_valid;
    logic                   r_frame_err;
    logic                   r_overrun;

    // Synchroniser resets to the idle (high) line level.
    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync <= '1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], serial_in};
        end
    end

    assign w_sync_q = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_BREAK;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt + 1'b1;
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_word_done   = 1'b0;
        w_word_bad    = 1'b0;
`ifdef DECODER_FRAMER_PARITY_EN
        w_par_err_nxt = r_par_err;
`endif
        case (r_state)
            S_BREAK: begin
                w_cnt_nxt = '0;
                if (w_sync_q) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_IDLE: begin
                w_cnt_nxt = '0;
                w_bit_nxt = '0;
                if (!w_sync_q) begin
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                // A start bit that is high again at mid-bit is a glitch.
                if (r_cnt == c_CNT_HALF) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = w_sync_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_nxt   = '0;
                    w_shift_nxt = {w_sync_q, r_shift[WORD_W-1:1]};
                    if (r_bit == c_BIT_LAST) begin
                        w_bit_nxt   = '0;
`ifdef DECODER_FRAMER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + 1'b1;
                    end
                end
            end
`ifdef DECODER_FRAMER_PARITY_EN
            S_PARITY: begin
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_nxt     = '0;
                    w_par_err_nxt = (^r_shift) ^ w_sync_q;
                    w_state_nxt   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (r_cnt == c_CNT_FULL) begin
                    w_cnt_nxt = '0;
                    if (!w_sync_q) begin
                        w_word_bad  = 1'b1;
                        w_state_nxt = S_BREAK;
`ifdef DECODER_FRAMER_PARITY_EN
                    end else if (r_par_err) begin
                        w_word_bad  = 1'b1;
                        w_state_nxt = S_IDLE;
`endif
                    end else begin
                        w_word_done = 1'b1;
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_BREAK;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_cnt       <= '0;
            r_bit       <= '0;
            r_shift     <= '0;
`ifdef DECODER_FRAMER_PARITY_EN
            r_par_err   <= 1'b0;
`endif
            r_word      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_cnt       <= w_cnt_nxt;
            r_bit       <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
`ifdef DECODER_FRAMER_PARITY_EN
            r_par_err   <= w_par_err_nxt;
`endif
            r_frame_err <= w_word_bad;
            r_overrun   <= w_word_done && r_valid && !word_ready;
            // A consume and a load on the same edge keep the register full.
            if (w_word_done && (!r_valid || word_ready)) begin
                r_word  <= r_shift;
                r_valid <= 1'b1;
            end else if (r_valid && word_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign word_out   = r_word;
    assign word_valid = r_valid;
    assign frame_err  = r_frame_err;
    assign overrun    = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_decoder_serial_framer.sv
`default_nettype none
//==============================================================================
// Module : tb_decoder_serial_framer
// Brief  : Scoreboard bench for decoder_serial_framer with a frame-level model.
// Rev    : 1.0 - initial release
//==============================================================================
module tb_decoder_serial_framer;

    localparam int WORD_W      = 7;
    localparam int OVERSAMPLE  = 4;
    localparam int SYNC_STAGES = 2;
    localparam int EV_FERR     = 0;
    localparam int EV_OVR      = 1;
`ifdef DECODER_FRAMER_PARITY_EN
    localparam bit c_PARITY    = 1'b1;
`else
    localparam bit c_PARITY    = 1'b0;
`endif
    localparam int c_LAT_MAX   = SYNC_STAGES + 35 + (c_PARITY ? OVERSAMPLE : 0);

    logic              clock      = 1'b0;
    logic              reset      = 1'b1;
    logic              serial_in  = 1'b1;
    logic              word_ready = 1'b1;
    logic [WORD_W-1:0] word_out;
    logic              word_valid;
    logic              frame_err;
    logic              overrun;

    int tests     = 0;
    int fails     = 0;
    int cyc       = 0;
    int last_fall = 0;

    logic [WORD_W-1:0] exp_words[$];
    int                exp_evt[$];

    decoder_serial_framer #(
        .WORD_W      (WORD_W),
        .OVERSAMPLE  (OVERSAMPLE),
        .SYNC_STAGES (SYNC_STAGES)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .serial_in  (serial_in),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .frame_err  (frame_err),
        .overrun    (overrun)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Frame-level reference: a frame is good iff stop is 1 and (with parity) data^parity is even.
    function automatic bit frame_ok(input logic [WORD_W-1:0] d, input bit stop_b, input bit par_b);
        bit par_good;
        par_good = !c_PARITY || ((^d) == par_b);
        return stop_b && par_good;
    endfunction

    task automatic idle(input int n);
        serial_in = 1'b1;
        repeat (n) @(negedge clock);
    endtask

    task automatic send_frame(input logic [WORD_W-1:0] d, input bit stop_b, input bit par_b);
        serial_in = 1'b0;
        last_fall = cyc;
        repeat (OVERSAMPLE) @(negedge clock);
        for (int i = 0; i < WORD_W; i++) begin
            serial_in = d[i];
            repeat (OVERSAMPLE) @(negedge clock);
        end
        if (c_PARITY) begin
            serial_in = par_b;
            repeat (OVERSAMPLE) @(negedge clock);
        end
        serial_in = stop_b;
        repeat (OVERSAMPLE) @(negedge clock);
    endtask

    // Push the model's expectation, then drive the frame.
    task automatic issue(input logic [WORD_W-1:0] d, input bit stop_b, input bit par_b,
                         input bit buf_full);
        if (!frame_ok(d, stop_b, par_b)) begin
            exp_evt.push_back(EV_FERR);
        end else if (buf_full) begin
            exp_evt.push_back(EV_OVR);
        end else begin
            exp_words.push_back(d);
        end
        send_frame(d, stop_b, par_b);
    endtask

    // Monitor: sample away from the active edge, after the stimulus has driven.
    logic              prev_valid = 1'b0;
    logic              prev_hs    = 1'b0;
    logic [WORD_W-1:0] prev_word  = '0;

    always begin
        @(negedge clock);
        #1;
        if (reset) begin
            prev_valid = 1'b0;
            prev_hs    = 1'b0;
        end else begin
            check("err_exclusive", int'(frame_err & overrun), 0);
            if (prev_valid && !prev_hs) begin
                check("valid_held", int'(word_valid), 1);
                check("word_held", int'(word_out), int'(prev_word));
            end
            if (word_valid && word_ready) begin
                check("word_expected", int'(exp_words.size() != 0), 1);
                if (exp_words.size() != 0) begin
                    check("word_value", int'(word_out), int'(exp_words.pop_front()));
                end
            end
            if (frame_err) begin
                check("ferr_expected", int'(exp_evt.size() != 0), 1);
                if (exp_evt.size() != 0) check("ferr_kind", exp_evt.pop_front(), EV_FERR);
            end
            if (overrun) begin
                check("ovr_expected", int'(exp_evt.size() != 0), 1);
                if (exp_evt.size() != 0) check("ovr_kind", exp_evt.pop_front(), EV_OVR);
            end
            prev_valid = word_valid;
            prev_hs    = word_valid && word_ready;
            prev_word  = word_out;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [WORD_W-1:0] d;
        bit                stop_b;
        bit                par_b;
        bit                got;

        repeat (3) @(negedge clock);
        check("rst_valid", int'(word_valid), 0);
        check("rst_word", int'(word_out), 0);
        check("rst_ferr", int'(frame_err), 0);
        check("rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        idle(6);

        // Single word, consumer always ready.
        word_ready = 1'b1;
        issue(7'h64, 1'b1, ^(7'h64), 1'b0);
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(negedge clock);
            if (word_valid) got = 1'b1;
        end
        check("t1_valid_seen", int'(got), 1);
        if (got) begin
            check("t1_latency", int'((cyc - last_fall) <= c_LAT_MAX), 1);
            check("t1_word", int'(word_out), 'h64);
            @(negedge clock);
            check("t1_valid_one_cycle", int'(word_valid), 0);
        end
        idle(6);

        // Back-to-back with a stalled consumer: second word overruns.
        word_ready = 1'b0;
        issue(7'h64, 1'b1, ^(7'h64), 1'b0);
        issue(7'h1B, 1'b1, ^(7'h1B), 1'b1);
        idle(4);
        check("t2_valid", int'(word_valid), 1);
        check("t2_word_kept", int'(word_out), 'h64);
        word_ready = 1'b1;
        @(negedge clock);
        check("t2_valid_drop", int'(word_valid), 0);
        idle(6);

        // One-cycle low glitch while idle.
        serial_in = 1'b0;
        @(negedge clock);
        idle(50);
        check("t3_no_word", int'(word_valid), 0);

        // Bad stop bit then line held low.
        issue(7'h55, 1'b0, ^(7'h55), 1'b0);
        serial_in = 1'b0;
        repeat (20) @(negedge clock);
        check("t4_no_word", int'(word_valid), 0);
        idle(8);
        issue(7'h2A, 1'b1, ^(7'h2A), 1'b0);
        idle(6);

        // Reset in the middle of the data bits of 7'h7F.
        serial_in = 1'b0;
        repeat (OVERSAMPLE) @(negedge clock);
        serial_in = 1'b1;
        repeat (3 * OVERSAMPLE) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("t5_rst_valid", int'(word_valid), 0);
        check("t5_rst_word", int'(word_out), 0);
        check("t5_rst_ferr", int'(frame_err), 0);
        check("t5_rst_ovr", int'(overrun), 0);
        reset = 1'b0;
        idle(40);
        issue(7'h01, 1'b1, ^(7'h01), 1'b0);
        idle(6);

        if (c_PARITY) begin
            issue(7'h64, 1'b1, 1'b1, 1'b0);
            idle(6);
            issue(7'h64, 1'b1, 1'b0, 1'b0);
            idle(6);
        end

        // Randomised frames against the model.
        for (int n = 0; n < 24; n++) begin
            d      = WORD_W'($urandom);
            stop_b = ($urandom_range(0, 4) != 0);
            par_b  = ^d;
            if (c_PARITY && $urandom_range(0, 3) == 0) par_b = ~par_b;
            issue(d, stop_b, par_b, 1'b0);
            if (stop_b) idle($urandom_range(0, 6));
            else        idle($urandom_range(2 * OVERSAMPLE, 3 * OVERSAMPLE));
        end

        idle(60);
        check("words_drained", exp_words.size(), 0);
        check("events_drained", exp_evt.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
